// File: rtl/instr_aligner_pkg.sv
// Shared types and constants for the instruction aligner.
// Holds the aligner FSM encoding and the RVC parcel rule.
package instr_aligner_pkg;

  typedef enum logic [1:0] {
    ALN_RUN  = 2'd0,
    ALN_SKIP = 2'd1,
    ALN_HALT = 2'd2
  } aln_state_e;

  localparam logic [1:0] RVC_OPC_FULL = 2'b11;

  function automatic logic is_rvc(input logic [15:0] hw);
    return hw[1:0] != RVC_OPC_FULL;
  endfunction

endpackage

// File: rtl/instr_aligner_hbuf.sv
// aln_hbuf: one-halfword holding register with valid flag; with ALIGNER_PARITY_EN
// an even-parity bit is captured on load and checked whenever the halfword is valid.
module aln_hbuf (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ld_i,
  input  logic        clr_i,
  input  logic [15:0] dat_i,
  output logic [15:0] dat_o,
  output logic        val_o,
  output logic        perr_o
);

  logic [15:0] data_q;
  logic        val_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= 16'h0000;
      val_q  <= 1'b0;
    end else if (ld_i) begin
      data_q <= dat_i;
      val_q  <= 1'b1;
    end else if (clr_i) begin
      val_q  <= 1'b0;
    end
  end

`ifdef ALIGNER_PARITY_EN
  logic par_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_q <= 1'b0;
    end else if (ld_i) begin
      par_q <= ^dat_i;
    end
  end

  assign perr_o = val_q & ((^data_q) ^ par_q);
`else
  assign perr_o = 1'b0;
`endif

  assign dat_o = data_q;
  assign val_o = val_q;

endmodule

// File: rtl/instr_aligner.sv
// Extracts one RV32C/RV32I instruction per cycle from aligned 32-bit fetch words
// into a registered decode slot; optional hbuf parity under ALIGNER_PARITY_EN.
module instr_aligner
  import instr_aligner_pkg::*;
(
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        s_flush_i,
  input  logic        s_flush_hw_i,
  input  logic        s_fetch_val_i,
  input  logic [31:0] s_fetch_data_i,
  input  logic        s_fetch_err_i,
  output logic        s_fetch_rdy_o,
  output logic        s_out_val_o,
  input  logic        s_out_rdy_i,
  output logic [31:0] s_out_instr_o,
  output logic        s_out_rvc_o,
  output logic        s_out_err_o
);

  aln_state_e  state_q, state_d;
  logic        val_q, val_d, rvc_q, rvc_d, err_q, err_d;
  logic [31:0] instr_q, instr_d;
  logic        hb_ld, hb_clr, hb_val, hb_perr, fetch_rdy, adv;
  logic [15:0] hb_dat;

  aln_hbuf u_hbuf (
    .clk_i  (s_clk_i),
    .rst_ni (s_resetn_i),
    .ld_i   (hb_ld),
    .clr_i  (hb_clr),
    .dat_i  (s_fetch_data_i[31:16]),
    .dat_o  (hb_dat),
    .val_o  (hb_val),
    .perr_o (hb_perr)
  );

  assign adv = ~val_q | s_out_rdy_i;

  always_comb begin
    state_d   = state_q;
    val_d     = val_q;
    instr_d   = instr_q;
    rvc_d     = rvc_q;
    err_d     = err_q;
    fetch_rdy = 1'b0;
    hb_ld     = 1'b0;
    hb_clr    = 1'b0;
    if (s_flush_i) begin
      val_d   = 1'b0;
      hb_clr  = 1'b1;
      state_d = s_flush_hw_i ? ALN_SKIP : ALN_RUN;
    end else if (adv) begin
      val_d = 1'b0;
      unique case (state_q)
        ALN_RUN: begin
          if (hb_val && is_rvc(hb_dat)) begin
            // Buffered RVC drains first; the pending fetch word waits.
            val_d   = 1'b1;
            instr_d = {16'h0000, hb_dat};
            rvc_d   = 1'b1;
            err_d   = hb_perr;
            hb_clr  = 1'b1;
            if (hb_perr) state_d = ALN_HALT;
          end else if (s_fetch_val_i) begin
            fetch_rdy = 1'b1;
            val_d     = 1'b1;
            if (s_fetch_err_i) begin
              instr_d = 32'h0;
              rvc_d   = 1'b0;
              err_d   = 1'b1;
              hb_clr  = 1'b1;
              state_d = ALN_HALT;
            end else if (hb_val) begin
              instr_d = {s_fetch_data_i[15:0], hb_dat};
              rvc_d   = 1'b0;
              err_d   = hb_perr;
              hb_ld   = ~hb_perr;
              hb_clr  = hb_perr;
              if (hb_perr) state_d = ALN_HALT;
            end else if (is_rvc(s_fetch_data_i[15:0])) begin
              instr_d = {16'h0000, s_fetch_data_i[15:0]};
              rvc_d   = 1'b1;
              err_d   = 1'b0;
              hb_ld   = 1'b1;
            end else begin
              instr_d = s_fetch_data_i;
              rvc_d   = 1'b0;
              err_d   = 1'b0;
            end
          end
        end
        ALN_SKIP: begin
          if (s_fetch_val_i) begin
            fetch_rdy = 1'b1;
            if (s_fetch_err_i) begin
              val_d   = 1'b1;
              instr_d = 32'h0;
              rvc_d   = 1'b0;
              err_d   = 1'b1;
              hb_clr  = 1'b1;
              state_d = ALN_HALT;
            end else begin
              hb_ld   = 1'b1;
              state_d = ALN_RUN;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      state_q <= ALN_RUN;
      val_q   <= 1'b0;
      instr_q <= 32'h0;
      rvc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      instr_q <= instr_d;
      rvc_q   <= rvc_d;
      err_q   <= err_d;
    end
  end

  assign s_fetch_rdy_o = fetch_rdy;
  assign s_out_val_o   = val_q;
  assign s_out_instr_o = instr_q;
  assign s_out_rvc_o   = rvc_q;
  assign s_out_err_o   = err_q;

endmodule

// File: tb/tb_instr_aligner.sv
// Bench for instr_aligner: directed scenarios, then randomized halfword streams
// checked against a parcel-level parser of the fetched halfword sequence.
module tb_instr_aligner;
  import instr_aligner_pkg::*;

  logic        s_clk_i = 1'b0;
  logic        s_resetn_i;
  logic        s_flush_i, s_flush_hw_i;
  logic        s_fetch_val_i, s_fetch_err_i, s_fetch_rdy_o;
  logic [31:0] s_fetch_data_i;
  logic        s_out_val_o, s_out_rdy_i, s_out_rvc_o, s_out_err_o;
  logic [31:0] s_out_instr_o;

  int passed = 0;
  int total  = 0;

  instr_aligner dut (
    .s_clk_i        (s_clk_i),
    .s_resetn_i     (s_resetn_i),
    .s_flush_i      (s_flush_i),
    .s_flush_hw_i   (s_flush_hw_i),
    .s_fetch_val_i  (s_fetch_val_i),
    .s_fetch_data_i (s_fetch_data_i),
    .s_fetch_err_i  (s_fetch_err_i),
    .s_fetch_rdy_o  (s_fetch_rdy_o),
    .s_out_val_o    (s_out_val_o),
    .s_out_rdy_i    (s_out_rdy_i),
    .s_out_instr_o  (s_out_instr_o),
    .s_out_rvc_o    (s_out_rvc_o),
    .s_out_err_o    (s_out_err_o)
  );

  always #5 s_clk_i = ~s_clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drv(input logic fv, input logic [31:0] d, input logic e,
                     input logic rdy, input logic fl, input logic flhw);
    s_fetch_val_i  = fv;
    s_fetch_data_i = d;
    s_fetch_err_i  = e;
    s_out_rdy_i    = rdy;
    s_flush_i      = fl;
    s_flush_hw_i   = flhw;
  endtask

  // Drive one cycle, check the combinational ready, then land on the next negedge.
  task automatic step(input string tag, input logic fv, input logic [31:0] d, input logic e,
                      input logic rdy, input logic fl, input logic flhw, input logic exp_rdy);
    drv(fv, d, e, rdy, fl, flhw);
    #1 chk({tag, "_fetch_rdy"}, s_fetch_rdy_o, exp_rdy);
    @(negedge s_clk_i);
  endtask

  task automatic expect_out(input string tag, input logic e, input logic r, input logic [31:0] ins);
    chk(tag, {s_out_val_o, s_out_err_o, s_out_rvc_o, s_out_instr_o}, {1'b1, e, r, ins});
  endtask

  task automatic expect_none(input string tag);
    chk(tag, s_out_val_o, 1'b0);
  endtask

  logic [31:0] words[$];
  logic [15:0] hws[$];
  logic [33:0] expq[$];
  int          nw, errk, h, idx, cyc;
  bit          skip, model_err, fv, rdy;

  initial begin
    s_resetn_i = 1'b0;
    drv(0, 32'h0, 0, 0, 0, 0);
    repeat (2) @(negedge s_clk_i);
    chk("reset_out", {s_out_val_o, s_out_err_o, s_out_rvc_o, s_out_instr_o}, 35'h0);
    chk("reset_rdy", s_fetch_rdy_o, 1'b0);
    s_resetn_i = 1'b1;
    @(negedge s_clk_i);

    // Two RVC parcels in one word.
    step("rvc_lo", 1, 32'h00014501, 0, 1, 0, 0, 1);
    expect_out("rvc_lo_out", 0, 1, 32'h4501);
    step("rvc_hi", 1, 32'h00A00513, 0, 1, 0, 0, 0);
    expect_out("rvc_hi_out", 0, 1, 32'h0001);
    step("full32", 1, 32'h00A00513, 0, 1, 0, 0, 1);
    expect_out("full32_out", 0, 0, 32'h00A00513);

    // 32-bit instruction straddling two words, with a gap in fetch.
    step("span_a", 1, 32'h05130001, 0, 1, 0, 0, 1);
    expect_out("span_a_out", 0, 1, 32'h0001);
    step("span_wait", 0, 32'h0, 0, 1, 0, 0, 0);
    expect_none("span_wait_out");
    step("span_b", 1, 32'h000000A0, 0, 1, 0, 0, 1);
    expect_out("span_b_out", 0, 0, 32'h00A00513);
    step("span_tail", 0, 32'h0, 0, 1, 0, 0, 0);
    expect_out("span_tail_out", 0, 1, 32'h0000);
    step("idle", 0, 32'h0, 0, 1, 0, 0, 0);
    expect_none("idle_out");

    // Decode back-pressure.
    step("hold_load", 1, 32'h45014501, 0, 1, 0, 0, 1);
    expect_out("hold_load_out", 0, 1, 32'h4501);
    for (int i = 0; i < 3; i++) begin
      step("hold", 1, 32'h00A00513, 0, 0, 0, 0, 0);
      expect_out("hold_out", 0, 1, 32'h4501);
    end
    step("hold_rel", 1, 32'h00A00513, 0, 1, 0, 0, 0);
    expect_out("hold_rel_out", 0, 1, 32'h4501);
    step("hold_next", 1, 32'h00A00513, 0, 1, 0, 0, 1);
    expect_out("hold_next_out", 0, 0, 32'h00A00513);

    // Flush to upper halfword with a valid output pending.
    step("flush_hw", 1, 32'h4505FFFF, 0, 1, 1, 1, 0);
    expect_none("flush_hw_out");
    step("skip", 1, 32'h4505FFFF, 0, 1, 0, 0, 1);
    expect_none("skip_bubble");
    step("skip_emit", 0, 32'h0, 0, 1, 0, 0, 0);
    expect_out("skip_emit_out", 0, 1, 32'h4505);
    step("skip_idle", 0, 32'h0, 0, 1, 0, 0, 0);
    expect_none("skip_idle_out");

    // Fetch error while hbuf holds the low half of a 32-bit instruction.
    step("err_pre", 1, 32'h05130001, 0, 1, 0, 0, 1);
    expect_out("err_pre_out", 0, 1, 32'h0001);
    step("err_word", 1, 32'h12345678, 1, 1, 0, 0, 1);
    expect_out("err_word_out", 1, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step("halt", 1, 32'h00A00513, 0, 1, 0, 0, 0);
      expect_none("halt_out");
    end
    step("halt_flush", 0, 32'h0, 0, 1, 1, 0, 0);
    expect_none("halt_flush_out");

`ifdef ALIGNER_PARITY_EN
    step("par_pre", 1, 32'h05130001, 0, 1, 0, 0, 1);
    expect_out("par_pre_out", 0, 1, 32'h0001);
    force dut.u_hbuf.data_q = 16'h0517;
    #1 release dut.u_hbuf.data_q;
    step("par_merge", 1, 32'h000000A0, 0, 1, 0, 0, 1);
    expect_out("par_merge_out", 1, 0, 32'h00A00517);
    chk("par_halt", dut.state_q, ALN_HALT);
    step("par_flush", 0, 32'h0, 0, 1, 1, 0, 0);
`endif

    // Randomized streams, compared with a sequential halfword parser.
    for (int r = 0; r < 16; r++) begin
      words.delete(); hws.delete(); expq.delete();
      nw   = $urandom_range(6, 16);
      skip = $urandom_range(0, 1);
      errk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nw - 1)) : -1;
      for (int i = 0; i < nw; i++) begin
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 1)) w[1:0] = 2'b11;
        if ($urandom_range(0, 1)) w[17:16] = 2'b11;
        words.push_back(w);
        hws.push_back(w[15:0]);
        hws.push_back(w[31:16]);
      end
      model_err = 0;
      h = skip ? 1 : 0;
      while (h < 2 * nw) begin
        if (h / 2 == errk) begin
          expq.push_back({1'b1, 1'b0, 32'h0}); model_err = 1; break;
        end
        if (hws[h][1:0] != 2'b11) begin
          expq.push_back({1'b0, 1'b1, 16'h0, hws[h]}); h += 1;
        end else begin
          if (h + 1 >= 2 * nw) break;
          if ((h + 1) / 2 == errk) begin
            expq.push_back({1'b1, 1'b0, 32'h0}); model_err = 1; break;
          end
          expq.push_back({1'b0, 1'b0, hws[h + 1], hws[h]}); h += 2;
        end
      end

      drv(0, 32'h0, 0, 1, 1, skip);
      @(negedge s_clk_i);
      idx = 0;
      cyc = 0;
      while (expq.size() != 0 && cyc < 600) begin
        fv  = (idx < nw) && ($urandom_range(0, 3) != 0);
        rdy = ($urandom_range(0, 3) != 0);
        drv(fv, fv ? words[idx] : $urandom, fv && (idx == errk), rdy, 0, 0);
        #1;
        if (s_out_val_o && !s_out_rdy_i) chk("rand_stall_rdy", s_fetch_rdy_o, 1'b0);
        if (s_out_val_o && s_out_rdy_i)
          chk("rand_out", {s_out_err_o, s_out_rvc_o, s_out_instr_o}, expq.pop_front());
        if (s_fetch_val_i && s_fetch_rdy_o) idx++;
        @(negedge s_clk_i);
        cyc++;
      end
      chk("rand_drained", expq.size(), 0);
      for (int i = 0; i < 6; i++) begin
        fv = (idx < nw);
        drv(fv, fv ? words[idx] : 32'h0, 0, 1, 0, 0);
        #1;
        chk("rand_extra", s_out_val_o, 1'b0);
        if (model_err && fv) chk("rand_halt_rdy", s_fetch_rdy_o, 1'b0);
        if (s_fetch_val_i && s_fetch_rdy_o) idx++;
        @(negedge s_clk_i);
      end
    end

    // Asynchronous reset mid-stream.
    step("pre_rst", 1, 32'h00014501, 0, 1, 0, 0, 1);
    #2 s_resetn_i = 1'b0;
    #1 chk("async_rst", {s_out_val_o, s_out_rvc_o, s_out_instr_o}, 34'h0);
    s_resetn_i = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_aligner.md
Name: instr_aligner

Overview:
- Sits between the fetch word queue and the decode stage.
- Takes 32-bit aligned fetch words and extracts one instruction per cycle, either 16-bit RVC or 32-bit, possibly spanning two fetch words.
- Presents each instruction to the decoders with an RVC flag, so the compressed decoder or the full decoder is selected and the PC advances by 2 or 4.
- Controls fetch-side back-pressure and realigns after pipeline flushes to halfword targets.

Parameters:
- none (widths fixed by RV32C).

Ports:
- s_clk_i  in  1  clock
- s_resetn_i  in  1  asynchronous active-low reset
- s_flush_i  in  1  discard buffered state; new fetch stream starts next cycle
- s_flush_hw_i  in  1  target address bit 1 of the flush (1 = start at upper halfword)
- s_fetch_val_i  in  1  fetch word valid
- s_fetch_data_i  in  32  fetch word, little-endian halfwords
- s_fetch_err_i  in  1  bus error on this fetch word
- s_fetch_rdy_o  out  1  word consumed this cycle (combinational)
- s_out_val_o  out  1  registered instruction valid
- s_out_rdy_i  in  1  decode accepts instruction
- s_out_instr_o  out  32  instruction; RVC in [15:0], [31:16]=0
- s_out_rvc_o  out  1  instruction is 16-bit
- s_out_err_o  out  1  fetch error (or parity error) attached

Behaviour:
- Parcel rule: a halfword with [1:0]!=2'b11 is RVC; otherwise it is the low half of a 32-bit instruction.
- Internal state: FSM {RUN, SKIP, HALT}, halfword buffer hbuf, flag hbuf_val.
- Output stage is a register. It advances when adv = ~s_out_val_o | s_out_rdy_i.
- Latency is 1 cycle from fetch acceptance to s_out_val_o.
- Reset values: s_out_val_o=0, s_out_instr_o=0, s_out_rvc_o=0, s_out_err_o=0, FSM=RUN, hbuf_val=0, hbuf=0.
- Flush has top priority, regardless of adv:
  - s_out_val_o←0, hbuf_val←0.
  - FSM←SKIP if s_flush_hw_i, else RUN.
  - s_fetch_rdy_o=0 in the flush cycle.
- The following cases are evaluated only when adv=1 and no flush. With adv=0, all state holds and s_fetch_rdy_o=0.
- RUN, hbuf_val=0, word valid, no error:
  - Low half RVC: emit RVC, hbuf←high half, hbuf_val←1, accept word.
  - Low half not RVC: emit the whole word, accept word.
- RUN, hbuf_val=1, hbuf RVC:
  - Emit hbuf as RVC, hbuf_val←0.
  - s_fetch_rdy_o=0, because the word must wait.
- RUN, hbuf_val=1, hbuf not RVC:
  - Needs a word. If one is valid: emit {word[15:0],hbuf}, hbuf←word[31:16], accept.
  - If no word is valid: no emission.
- SKIP: on a valid word without error, hbuf←word[31:16], hbuf_val←1, FSM←RUN, accept, no emission (1-cycle bubble).
- Error word (s_fetch_err_i=1) when the word would be consumed (any case above except the hbuf-RVC case):
  - Emit an entry with err=1, instr=0, rvc=0.
  - Accept the word, hbuf_val←0, FSM←HALT.
- HALT: s_fetch_rdy_o=0, no emission; leaves only on flush.
- If no emission occurs while adv=1, s_out_val_o←0.
- A simultaneous flush and s_out_rdy_i consumes nothing new; a pending output is dropped.
- Reset mid-operation returns all state to reset values immediately.

Optional Feature:
- ALIGNER_PARITY_EN.
- Defined: hbuf carries an even-parity bit written on load.
  - When hbuf is emitted (alone or merged), a parity mismatch sets s_out_err_o=1 and FSM←HALT, as for a fetch error.
- Undefined: no parity flop; s_out_err_o reflects only s_fetch_err_i.

Decomposition:
- p_hardisc gains the aligner FSM enum (ALN_RUN, ALN_SKIP, ALN_HALT) and the constant RVC_OPC_FULL=2'b11.
- One sub-module, aln_hbuf: halfword register with valid, and with parity generate/check under ALIGNER_PARITY_EN.
- The output stage stays inline.

Test Plan:
- Word 0x00014501 (c.li a0,0 then c.nop), out_rdy=1:
  - Cycle+1: instr 0x4501, rvc=1.
  - Cycle+2: instr 0x0001, rvc=1, with s_fetch_rdy_o=0 during the hbuf emission.
- Words 0x00A0_0513 then 0x4501_0093 (32-bit addi, then spanning case): outputs 0x00A00513, then next word handling per rules.
  - Check spanning with word1=0x05130001, word2=0x000000A0 → 0x0001, then 0x00A00513.
- Flush with s_flush_hw_i=1, word 0x4505FFFF: no output for one cycle, then 0x4505 rvc=1; the low half 0xFFFF is never emitted.
- hbuf holds 0x0513 (low of 32-bit) and the next word has s_fetch_err_i=1:
  - Output err=1, instr=0.
  - Afterwards, s_fetch_rdy_o=0 and no output until flush.
- Hold s_out_rdy_i=0 for 3 cycles with out valid: output stable, s_fetch_rdy_o=0. Release → next instruction on the following cycle.
- ALIGNER_PARITY_EN defined: force-flip one hbuf bit → the merged instruction is emitted with err=1 and FSM=HALT.
